mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit for the multi-cycle MIPS datapath. It takes operands from the A/B registers and produces the 64-bit product or the quotient/remainder pair. The results feed the HI and LO registers. The control unit starts an operation with a one-cycle pulse, stalls while `busy`, and latches HI/LO on `done`. It also reports divide-by-zero for the exception path, which selects vector 253/254/255 through mux_EXCP.

---
 rtl/mult_div_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit for the
// multi-cycle MIPS datapath; results land in the HI/LO register pair.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DZ   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             op_r, op_s;
    logic             a_neg_r, a_neg_s;
    logic             b_neg_r, b_neg_s;
    logic [WIDTH-1:0] acc_hi_r, acc_hi_s;
    logic [WIDTH-1:0] acc_lo_r, acc_lo_s;
    logic             q_r, q_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             div0_r, div0_s;

    logic [WIDTH:0]   booth_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
        return c ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Booth partial step: sign-extended add/subtract of the multiplicand into P_hi.
    always_comb begin
        booth_s = {acc_hi_r[WIDTH-1], acc_hi_r};
        case ({acc_lo_r[0], q_r})
            2'b01:   booth_s = {acc_hi_r[WIDTH-1], acc_hi_r} + {b_r[WIDTH-1], b_r};
            2'b10:   booth_s = {acc_hi_r[WIDTH-1], acc_hi_r} - {b_r[WIDTH-1], b_r};
            default: booth_s = {acc_hi_r[WIDTH-1], acc_hi_r};
        endcase
    end

    // Restoring-division trial subtract; the extra top bit is the borrow.
    always_comb begin
        shifted_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        trial_s   = {1'b0, shifted_s} - {2'b00, b_r};
    end

    // Next-state and datapath update for the whole FSM.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        op_s     = op_r;
        a_neg_s  = a_neg_r;
        b_neg_s  = b_neg_r;
        acc_hi_s = acc_hi_r;
        acc_lo_s = acc_lo_r;
        q_s      = q_r;
        b_s      = b_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        div0_s   = div0_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    op_s     = op;
                    a_neg_s  = a[WIDTH-1];
                    b_neg_s  = b[WIDTH-1];
                    cnt_s    = {CNT_W{1'b0}};
                    acc_hi_s = {WIDTH{1'b0}};
                    acc_lo_s = op ? magnitude(a) : a;
                    b_s      = op ? magnitude(b) : b;
                    q_s      = 1'b0;
                    busy_s   = 1'b1;
                    div0_s   = 1'b0;
                    if (op && (b == {WIDTH{1'b0}})) begin
                        state_s = S_DZ;
                    end else if (op) begin
                        state_s = S_DIV;
                    end else begin
                        state_s = S_MUL;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL: begin
                acc_hi_s = booth_s[WIDTH:1];
                acc_lo_s = {booth_s[0], acc_lo_r[WIDTH-1:1]};
                q_s      = acc_lo_r[0];
                cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_ITER) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_MUL;
                end
            end
            S_DIV: begin
                if (!trial_s[WIDTH+1]) begin
                    acc_hi_s = WIDTH'(trial_s);
                    acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_s = shifted_s[WIDTH-1:0];
                    acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
                end
                cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_ITER) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_DIV;
                end
            end
            S_FIX: begin
                // Quotient truncates toward zero; remainder follows the dividend's sign.
                if (op_r) begin
                    lo_s = neg_if(acc_lo_r, a_neg_r ^ b_neg_r);
                    hi_s = neg_if(acc_hi_r, a_neg_r);
                end else begin
                    lo_s = acc_lo_r;
                    hi_s = acc_hi_r;
                end
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            S_DZ: begin
                done_s  = 1'b1;
                div0_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 1'b0;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
            q_r      <= 1'b0;
            b_r      <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            div0_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            op_r     <= op_s;
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            acc_hi_r <= acc_hi_s;
            acc_lo_r <= acc_lo_s;
            q_r      <= q_s;
            b_r      <= b_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            div0_r   <= div0_s;
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;
    assign div0 = div0_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors queue their expected
// {div0, hi, lo}; a forked monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div0;

    int           n_vec = 0;
    int           n_bad = 0;
    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [2*W:0] e;
        logic         prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                check("done_width", 64'(prev_done), 64'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 with nothing pending, expected done=0");
                end else begin
                    e = exp_q.pop_front();
                    check("hi", 64'(hi), 64'(e[2*W-1:W]));
                    check("lo", 64'(lo), 64'(e[W-1:0]));
                    check("div0", 64'(div0), 64'(e[2*W]));
                end
            end
            prev_done = done;
        end
    endtask

    task automatic run_op(input string nm, input logic o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input logic ed, input int elat,
                          input int glitch, input bit b2b);
        int  lat;
        bit  got;
        exp_q.push_back({ed, eh, el});
        if (!b2b) @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        lat   = 0;
        got   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (i == 0) begin
                a  = $urandom;
                b  = $urandom;
                op = ~o;
            end
            start = (glitch != 0) && (lat == glitch);
            if (start) begin
                op = 1'b1;
                b  = {W{1'b0}};
            end
            if (busy) lat++;
        end
        start = 1'b0;
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: no done within 100 cycles, expected done", nm);
        end
        check({nm, "_latency"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = {W{1'b0}};
        b     = {W{1'b0}};
        fork
            monitor_loop();
        join_none
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 10, 1'b0);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 0, 1'b0);
        run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33, 0, 1'b0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0, 1'b0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33, 0, 1'b1);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 0, 1'b0);
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("div0_sticky", 64'(div0), 64'd1);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 0, 1'b0);

        // Abort: MULT started, ignored start at cycle 10, reset at cycle 20.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd123;
        b     = 32'd456;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = (i == 10);
        end
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_div0", 64'(div0), 64'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_busy", 64'(busy), 64'd0);

        run_op("mul_3_4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
